// File: rtl/clock_disp_pkg.sv
// clock_disp_pkg: shared constants and writer state for the clock renderer.
// Used by im_addr_gen and clock_im_writer.
package clock_disp_pkg;

    localparam int CHAR_W    = 13;
    localparam int CHAR_H    = 24;
    localparam int NUM_CHARS = 8;
    localparam int PIX_W     = 24;
    localparam int FRAME_PIX = CHAR_W * CHAR_H * NUM_CHARS;

    localparam logic [PIX_W-1:0] FG_PIX = 24'hffffff;
    localparam logic [PIX_W-1:0] BG_PIX = 24'h000000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } wr_state_t;

endpackage

// File: rtl/im_addr_gen.sv
// im_addr_gen: incremental col/row/glyph address generator for the IM writer.
// addr/last_pix describe the pixel accepted this cycle (reload-aware).
module im_addr_gen
    import clock_disp_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IM_AW    = 16,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reload,
    input  logic             advance,
    output logic [IM_AW-1:0] addr,
    output logic             last_pix
);

    localparam logic [IM_AW-1:0] ROW0     = IM_AW'(ORIGIN_Y * IMG_W);
    localparam logic [IM_AW-1:0] GLY0     = IM_AW'(ORIGIN_X);
    localparam logic [IM_AW-1:0] ROW_STEP = IM_AW'(IMG_W);
    localparam logic [IM_AW-1:0] GLY_STEP = IM_AW'(CHAR_W);

    logic [3:0]       col_q, col_c;
    logic [4:0]       row_q, row_c;
    logic [2:0]       glyph_q, glyph_c;
    logic [IM_AW-1:0] row_base_q, row_base_c;
    logic [IM_AW-1:0] glyph_base_q, glyph_base_c;

    // A reload on an accepting beat makes that beat pixel 0 of the new frame.
    always_comb begin
        col_c        = col_q;
        row_c        = row_q;
        glyph_c      = glyph_q;
        row_base_c   = row_base_q;
        glyph_base_c = glyph_base_q;
        if (reload) begin
            col_c        = '0;
            row_c        = '0;
            glyph_c      = '0;
            row_base_c   = ROW0;
            glyph_base_c = GLY0;
        end
    end

    assign addr     = row_base_c + glyph_base_c + IM_AW'(col_c);
    assign last_pix = (glyph_c == 3'(NUM_CHARS - 1)) &&
                      (row_c == 5'(CHAR_H - 1)) &&
                      (col_c == 4'(CHAR_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            glyph_q      <= '0;
            row_base_q   <= ROW0;
            glyph_base_q <= GLY0;
        end else if (advance || reload) begin
            col_q        <= col_c;
            row_q        <= row_c;
            glyph_q      <= glyph_c;
            row_base_q   <= row_base_c;
            glyph_base_q <= glyph_base_c;
            if (advance) begin
                if (col_c == 4'(CHAR_W - 1)) begin
                    col_q <= '0;
                    if (row_c == 5'(CHAR_H - 1)) begin
                        row_q        <= '0;
                        glyph_q      <= glyph_c + 3'd1;
                        row_base_q   <= ROW0;
                        glyph_base_q <= glyph_base_c + GLY_STEP;
                    end else begin
                        row_q      <= row_c + 5'd1;
                        row_base_q <= row_base_c + ROW_STEP;
                    end
                end else begin
                    col_q <= col_c + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/clock_im_writer.sv
// clock_im_writer: writes the renderer's 8-glyph pixel stream into image memory.
// Option CLK_WR_TRANSPARENT_EN: background pixels advance but are not written.
module clock_im_writer
    import clock_disp_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IM_AW    = 16,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic [IM_AW-1:0] IM_A,
    output logic [PIX_W-1:0] IM_D,
    output logic             IM_WEN,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    wr_state_t        state_q, state_d;
    logic [IM_AW-1:0] addr;
    logic             last_pix;
    logic             accept;
    logic             restart;
    logic             pix_err;
    logic             wr_en;

    assign accept  = pix_valid && (state_q == RUN);
    assign restart = frame_start && (state_q == RUN);
    assign pix_err = pix_valid && (state_q != RUN);

`ifdef CLK_WR_TRANSPARENT_EN
    assign wr_en = accept && (pix_data != BG_PIX);
`else
    assign wr_en = accept;
`endif

    im_addr_gen #(
        .IMG_W   (IMG_W),
        .IM_AW   (IM_AW),
        .ORIGIN_X(ORIGIN_X),
        .ORIGIN_Y(ORIGIN_Y)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .reload  (frame_start),
        .advance (accept),
        .addr    (addr),
        .last_pix(last_pix)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_start) state_d = RUN;
            RUN:     if (accept && last_pix) state_d = DONE;
            DONE:    state_d = frame_start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            IM_A    <= '0;
            IM_D    <= '0;
            IM_WEN  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            IM_WEN  <= wr_en;
            if (accept) begin
                IM_A <= addr;
                IM_D <= pix_data;
            end
            // A stray pixel outranks the clear from an idle frame_start.
            if (pix_err || restart) begin
                err <= 1'b1;
            end else if (frame_start) begin
                err <= 1'b0;
            end
        end
    end

    assign busy       = (state_q == RUN);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_clock_im_writer.sv
// tb_clock_im_writer: self-checking bench for clock_im_writer.
// Drives a default DUT and an offset-origin DUT with the same stream.
module tb_clock_im_writer;
    import clock_disp_pkg::*;

    localparam int NPIX = 2496;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        pix_valid;
    logic [23:0] pix_data;

    logic [15:0] a_a, o_a;
    logic [23:0] a_d, o_d;
    logic        a_wen, o_wen, a_busy, o_busy, a_fd, o_fd, a_err, o_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] got_a[$], got_oa[$], exp_a[$], exp_oa[$];
    logic [23:0] got_d[$], got_od[$], exp_d[$];
    int          fd_count;

    clock_im_writer dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .IM_A(a_a), .IM_D(a_d), .IM_WEN(a_wen),
        .busy(a_busy), .frame_done(a_fd), .err(a_err)
    );

    clock_im_writer #(.ORIGIN_X(20), .ORIGIN_Y(100)) dut_o (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .IM_A(o_a), .IM_D(o_d), .IM_WEN(o_wen),
        .busy(o_busy), .frame_done(o_fd), .err(o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_wen) begin
            got_a.push_back(a_a);
            got_d.push_back(a_d);
        end
        if (o_wen) begin
            got_oa.push_back(o_a);
            got_od.push_back(o_d);
        end
        if (a_fd) fd_count++;
    end

    function automatic logic [15:0] pix_addr(int k, int ox, int oy);
        int g, r, c;
        g = k / 312;
        r = (k % 312) / 13;
        c = k % 13;
        return 16'((oy + r) * 256 + ox + g * 13 + c);
    endfunction

    function automatic bit writes(logic [23:0] d);
`ifdef CLK_WR_TRANSPARENT_EN
        return d != 24'h0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [23:0] rand_nz();
        logic [23:0] v;
        v = ($urandom_range(0, 1) == 0) ? FG_PIX : 24'($urandom);
        if (v == 24'h0) v = 24'h1;
        return v;
    endfunction

    function automatic int seq_bad();
        int b = 0;
        if (got_a.size() != exp_a.size()) b++;
        if (got_oa.size() != exp_oa.size()) b++;
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) b++;
        end
        for (int i = 0; i < got_oa.size() && i < exp_oa.size(); i++) begin
            if (got_oa[i] !== exp_oa[i] || got_od[i] !== exp_d[i]) b++;
        end
        return b;
    endfunction

    task automatic clear_q();
        got_a.delete(); got_d.delete(); got_oa.delete(); got_od.delete();
        exp_a.delete(); exp_d.delete(); exp_oa.delete();
        fd_count = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        tick(); tick();
        reset = 1'b0;
        clear_q();
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_pix(int k, logic [23:0] d);
        pix_valid = 1'b1;
        pix_data  = d;
        if (writes(d)) begin
            exp_a.push_back(pix_addr(k, 0, 0));
            exp_oa.push_back(pix_addr(k, 20, 100));
            exp_d.push_back(d);
        end
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (a_a !== 16'h0 || a_d !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_a_d: got A=%0h D=%0h expected 0 0", a_a, a_d);
        end
        n_checks++;
        if (a_wen !== 1'b0 || o_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wen: got %b/%b expected 0", a_wen, o_wen);
        end
        n_checks++;
        if ({a_busy, a_fd, a_err, o_busy, o_fd, o_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {a_busy, a_fd, a_err, o_busy, o_fd, o_err});
        end
    endtask

    task automatic test_nominal();
        logic [23:0] d;
        do_reset();
        start_frame();
        n_checks++;
        if (a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nom_busy_rise: got %b expected 1", a_busy);
        end
        for (int k = 0; k < NPIX; k++) begin
            d = rand_nz();
            send_pix(k, d);
        end
        n_checks++;
        if (a_fd !== 1'b1 || a_wen !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_done: got fd=%b wen=%b busy=%b expected 1 1 0",
                     a_fd, a_wen, a_busy);
        end
        tick();
        n_checks++;
        if (a_fd !== 1'b0 || a_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_after: got fd=%b wen=%b expected 0 0", a_fd, a_wen);
        end
        tick();
        n_checks++;
        if (seq_bad() != 0) begin
            n_fail++;
            $display("FAIL nom_seq: got %0d bad entries expected 0", seq_bad());
        end
        n_checks++;
        if (got_a.size() != NPIX) begin
            n_fail++;
            $display("FAIL nom_count: got %0d expected %0d", got_a.size(), NPIX);
        end
        n_checks++;
        if (got_a[0] !== 16'd0 || got_a[12] !== 16'd12 || got_a[13] !== 16'd256 ||
            got_a[312] !== 16'd13 || got_a[NPIX-1] !== 16'd5991) begin
            n_fail++;
            $display("FAIL nom_spots: got %0d %0d %0d %0d %0d expected 0 12 256 13 5991",
                     got_a[0], got_a[12], got_a[13], got_a[312], got_a[NPIX-1]);
        end
        n_checks++;
        if (got_oa[0] !== 16'd25620 || got_oa[NPIX-1] !== 16'd31611) begin
            n_fail++;
            $display("FAIL origin_spots: got %0d %0d expected 25620 31611",
                     got_oa[0], got_oa[NPIX-1]);
        end
        n_checks++;
        if (fd_count != 1 || a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL nom_fd_err: got fd=%0d err=%b expected 1 0", fd_count, a_err);
        end
    endtask

    task automatic test_gapped();
        int busy_bad = 0;
        do_reset();
        start_frame();
        for (int k = 0; k < NPIX; k++) begin
            send_pix(k, rand_nz());
            if (k != NPIX - 1) begin
                tick();
                if (a_busy !== 1'b1) busy_bad++;
            end
        end
        n_checks++;
        if (a_fd !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_done: got fd=%b busy=%b expected 1 0", a_fd, a_busy);
        end
        tick(); tick();
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL gap_busy: got %0d low cycles expected 0", busy_bad);
        end
        n_checks++;
        if (got_a.size() != NPIX || seq_bad() != 0) begin
            n_fail++;
            $display("FAIL gap_seq: got %0d writes %0d bad expected %0d 0",
                     got_a.size(), seq_bad(), NPIX);
        end
    endtask

    task automatic test_restart();
        do_reset();
        start_frame();
        for (int k = 0; k < 500; k++) send_pix(k, rand_nz());
        frame_start = 1'b1;
        send_pix(0, rand_nz());
        frame_start = 1'b0;
        n_checks++;
        if (a_err !== 1'b1 || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_err: got err=%b busy=%b expected 1 1", a_err, a_busy);
        end
        for (int k = 1; k < NPIX; k++) send_pix(k, rand_nz());
        n_checks++;
        if (a_fd !== 1'b1 || a_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_done: got fd=%b err=%b expected 1 1", a_fd, a_err);
        end
        tick(); tick();
        n_checks++;
        if (got_a.size() != 500 + NPIX || got_a[500] !== 16'd0 || seq_bad() != 0) begin
            n_fail++;
            $display("FAIL rst_seq: got n=%0d a500=%0d bad=%0d expected %0d 0 0",
                     got_a.size(), got_a[500], seq_bad(), 500 + NPIX);
        end
        n_checks++;
        if (fd_count != 1) begin
            n_fail++;
            $display("FAIL rst_fd: got %0d expected 1", fd_count);
        end
        start_frame();
        n_checks++;
        if (a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_clear: got err=%b expected 0", a_err);
        end
    endtask

    task automatic test_idle_pixel();
        int wen_seen = 0;
        do_reset();
        pix_valid = 1'b1;
        pix_data  = FG_PIX;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_wen !== 1'b0) wen_seen++;
        end
        pix_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (wen_seen != 0 || got_a.size() != 0) begin
            n_fail++;
            $display("FAIL idle_wen: got %0d/%0d writes expected 0", wen_seen, got_a.size());
        end
        n_checks++;
        if (a_err !== 1'b1 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_err: got err=%b busy=%b expected 1 0", a_err, a_busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_frame();
        for (int k = 0; k < 1000; k++) send_pix(k, rand_nz());
        reset     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = FG_PIX;
        tick();
        reset     = 1'b0;
        pix_valid = 1'b0;
        n_checks++;
        if (a_a !== 16'h0 || a_d !== 24'h0 || a_wen !== 1'b0 ||
            a_busy !== 1'b0 || a_fd !== 1'b0 || a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got A=%0h D=%0h wen=%b busy=%b fd=%b err=%b expected all 0",
                     a_a, a_d, a_wen, a_busy, a_fd, a_err);
        end
        repeat (5) tick();
        n_checks++;
        if (got_a.size() != 1000 || seq_bad() != 0) begin
            n_fail++;
            $display("FAIL mid_writes: got %0d writes %0d bad expected 1000 0",
                     got_a.size(), seq_bad());
        end
    endtask

    task automatic test_alternating();
        logic [23:0] d;
        do_reset();
        start_frame();
        for (int k = 0; k < NPIX; k++) begin
            d = (k % 2 == 0) ? FG_PIX : BG_PIX;
            send_pix(k, d);
        end
        n_checks++;
        if (a_fd !== 1'b1 || a_wen !== writes(BG_PIX)) begin
            n_fail++;
            $display("FAIL alt_done: got fd=%b wen=%b expected 1 %b",
                     a_fd, a_wen, writes(BG_PIX));
        end
        tick(); tick();
        n_checks++;
        if (seq_bad() != 0 || fd_count != 1) begin
            n_fail++;
            $display("FAIL alt_seq: got %0d bad fd=%0d expected 0 1", seq_bad(), fd_count);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gapped();
        test_restart();
        test_idle_pixel();
        test_reset_mid();
        test_alternating();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
